// File: rtl/shift_ctrl_pkg.sv
// Shared types and defaults for the shift/load controller.
// FSM state encoding and the default word width.
package shift_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_load_ctrl.sv
// Serializes a parallel word into an external shift register and reads it back.
// Define SHIFT_LOAD_CTRL_CHECK_EN to build the readback mismatch check.
module shift_load_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sr_data,
  output logic             sr_shift_enable,
  input  logic [WIDTH-1:0] sr_stored_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             mismatch
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state_q, state_d;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] idx;
  logic [WIDTH-1:0] word_q;
  logic accept;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bit_cnt <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        word_q  <= in_data;
        bit_cnt <= '0;
      end else if (state_q == SHIFT && bit_cnt != LAST) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    in_ready        = 1'b0;
    busy            = 1'b1;
    sr_shift_enable = 1'b0;
    sr_data         = 1'b0;
    out_valid       = 1'b0;
    out_data        = '0;
    idx             = (MSB_FIRST != 0) ? (LAST - bit_cnt) : bit_cnt;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = SHIFT;
      end
      SHIFT: begin
        sr_shift_enable = 1'b1;
        sr_data         = word_q[idx];
        if (bit_cnt == LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_data  = sr_stored_data;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SHIFT_LOAD_CTRL_CHECK_EN
  // LSB-first leaves bit 0 of the word at the far end of the register.
  logic [WIDTH-1:0] word_rev;
  logic [WIDTH-1:0] expect_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign word_rev[i] = word_q[WIDTH-1-i];
  end

  assign expect_q = (MSB_FIRST != 0) ? word_q : word_rev;
  assign mismatch = (state_q == DONE) && (sr_stored_data != expect_q);
`else
  assign mismatch = 1'b0;
`endif

endmodule
